// File: rtl/amber_interrupt_controller_v2.sv
// Wishbone interrupt controller: synchronises N_SRC sources, latches edges or follows levels,
// and drives registered IRQ/FIRQ requests plus a lowest-index IRQ vector to the Amber core.
module amber_interrupt_controller_v2 #(
  parameter int N_SRC       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WB_DWIDTH   = 32,
  parameter int WB_SWIDTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_wb_sel,
  input  logic                 i_wb_we,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  input  logic [N_SRC-1:0]     i_int,
  output logic                 o_irq,
  output logic                 o_firq
);

  localparam logic [31:0] DEFAULT_RDATA = 32'h2233_4455;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] s, prev_q, rise;
  logic [N_SRC-1:0] irq_en_q, firq_en_q, soft_q, mode_q, latch_q, pending_q;
  logic [N_SRC-1:0] irq_status, firq_status, w1c, hw_next, wd;
  logic             vec_valid_q, vec_hit;
  logic [4:0]       vec_id_q, vec_id_next;
  logic [31:0]      rdata_q, rd_next, wdata32;
  logic             rd_d1_q, start_write, start_read, ack;
  logic [7:0]       adr8;
  logic             wr_enset, wr_enclr, wr_softset, wr_softclr, wr_pend, wr_mode;
  logic             wr_fenset, wr_fenclr;
  logic             unused_ok;

  // Handshake: a write is acked in the cycle stb is seen; a read is acked one cycle
  // later with data captured on start_read. The master holds stb until it sees ack.
  assign start_write = i_wb_stb & i_wb_we & ~rd_d1_q;
  assign ack         = i_rst_n & i_wb_stb & (start_write | rd_d1_q);
  assign start_read  = i_wb_stb & ~i_wb_we & ~ack;
  assign o_wb_ack    = ack;
  assign o_wb_err    = 1'b0;
  assign adr8        = i_wb_adr[7:0];

  generate
    if (WB_DWIDTH == 128) begin : g_wide
      always_comb begin
        wdata32 = i_wb_dat[31:0];
        case (i_wb_adr[3:2])
          2'd1:    wdata32 = i_wb_dat[63:32];
          2'd2:    wdata32 = i_wb_dat[95:64];
          2'd3:    wdata32 = i_wb_dat[127:96];
          default: wdata32 = i_wb_dat[31:0];
        endcase
      end
    end else begin : g_narrow
      assign wdata32 = i_wb_dat[31:0];
    end
  endgenerate

  assign o_wb_dat = {(WB_DWIDTH/32){rdata_q}};
  assign wd       = wdata32[N_SRC-1:0];

  assign wr_enset   = start_write & (adr8 == 8'h08);
  assign wr_enclr   = start_write & (adr8 == 8'h0C);
  assign wr_softset = start_write & (adr8 == 8'h10);
  assign wr_softclr = start_write & (adr8 == 8'h14);
  assign wr_pend    = start_write & (adr8 == 8'h18);
  assign wr_mode    = start_write & (adr8 == 8'h1C);
  assign wr_fenset  = start_write & (adr8 == 8'h28);
  assign wr_fenclr  = start_write & (adr8 == 8'h2C);

  assign s           = sync_q[SYNC_STAGES-1];
  assign rise        = s & ~prev_q;
  assign w1c         = wr_pend ? wd : '0;
  // A rise arriving with a clear of the same bit keeps the bit set.
  assign hw_next     = (latch_q & ~w1c) | rise;
  assign irq_status  = pending_q & irq_en_q & ~firq_en_q;
  assign firq_status = pending_q & firq_en_q;

  function automatic logic [31:0] zx(input logic [N_SRC-1:0] v);
    zx = '0;
    zx[N_SRC-1:0] = v;
  endfunction

  always_comb begin
    vec_hit     = 1'b0;
    vec_id_next = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (irq_status[i]) begin
        vec_hit     = 1'b1;
        vec_id_next = 5'(i);
      end
    end
  end

  always_comb begin
    rd_next = DEFAULT_RDATA;
    case (adr8)
      8'h00:   rd_next = zx(irq_status);
      8'h04:   rd_next = zx(s);
      8'h08:   rd_next = zx(irq_en_q);
      8'h10:   rd_next = zx(soft_q);
      8'h18:   rd_next = zx(pending_q);
      8'h1C:   rd_next = zx(mode_q);
      8'h20:   rd_next = zx(firq_status);
      8'h28:   rd_next = zx(firq_en_q);
      8'h30:   rd_next = {vec_valid_q, 26'd0, vec_id_q};
      default: rd_next = DEFAULT_RDATA;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= i_int;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_q      <= '0;
      irq_en_q    <= '0;
      firq_en_q   <= '0;
      soft_q      <= '0;
      mode_q      <= '0;
      latch_q     <= '0;
      pending_q   <= '0;
      o_irq       <= 1'b0;
      o_firq      <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_id_q    <= '0;
      rdata_q     <= '0;
      rd_d1_q     <= 1'b0;
    end else begin
      prev_q <= s;
      if (wr_enset)   irq_en_q  <= irq_en_q | wd;
      if (wr_enclr)   irq_en_q  <= irq_en_q & ~wd;
      if (wr_fenset)  firq_en_q <= firq_en_q | wd;
      if (wr_fenclr)  firq_en_q <= firq_en_q & ~wd;
      if (wr_softset) soft_q    <= soft_q | wd;
      if (wr_softclr) soft_q    <= soft_q & ~wd;
      if (wr_mode)    mode_q    <= wd;
      // Level-mode bits hold no latch, so switching edge->level drops it.
      latch_q     <= hw_next & mode_q;
      pending_q   <= (mode_q & hw_next) | (~mode_q & s) | soft_q;
      o_irq       <= |irq_status;
      o_firq      <= |firq_status;
      vec_valid_q <= vec_hit;
      vec_id_q    <= vec_id_next;
      if (start_read) rdata_q <= rd_next;
      rd_d1_q     <= start_read;
    end
  end

  assign unused_ok = ^{i_wb_sel, i_wb_cyc, i_wb_adr[31:8], i_wb_adr[1:0], wdata32};

endmodule

// File: tb/tb_amber_interrupt_controller_v2.sv
// Bench for amber_interrupt_controller_v2: directed scenarios plus random bus/source traffic,
// checked against a behavioural model of the register file and request outputs.
module tb_amber_interrupt_controller_v2;
  localparam int N_SRC = 16;
  localparam int SS    = 2;
  localparam int DW    = 32;
  localparam int SW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   adr = '0;
  logic [SW-1:0] sel = '1;
  logic          we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic [DW-1:0] dat_w = '0;
  logic [DW-1:0] dat_r;
  logic          ack, err, irq, firq;
  logic [N_SRC-1:0] int_in = '0;

  int checks = 0;
  int errors = 0;

  amber_interrupt_controller_v2 #(.N_SRC(N_SRC), .SYNC_STAGES(SS), .WB_DWIDTH(DW), .WB_SWIDTH(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we),
    .i_wb_dat(dat_w), .o_wb_dat(dat_r), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_ack(ack), .o_wb_err(err), .i_int(int_in), .o_irq(irq), .o_firq(firq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [N_SRC-1:0] m_hist [SS+1];   // m_hist[k]: i_int as sampled k+1 edges ago
  logic [N_SRC-1:0] m_en, m_fen, m_soft, m_mode, m_lat, m_pend;
  logic             m_irq, m_firq, m_vvalid;
  logic [4:0]       m_vid;
  logic             m_live = 1'b0;
  logic [N_SRC-1:0] t_s, t_prev, t_rise, t_w1c, t_st, t_lat, t_d;
  logic [7:0]       t_a;
  logic             t_wr, t_found;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= SS; k++) m_hist[k] = '0;
      m_en = '0; m_fen = '0; m_soft = '0; m_mode = '0; m_lat = '0; m_pend = '0;
      m_irq = 1'b0; m_firq = 1'b0; m_vvalid = 1'b0; m_vid = '0;
      m_live = 1'b1;
    end else begin
      t_s    = m_hist[SS-1];
      t_prev = m_hist[SS];
      t_rise = t_s & ~t_prev;
      t_wr   = stb && we;
      t_a    = adr[7:0];
      t_d    = dat_w[N_SRC-1:0];
      t_w1c  = (t_wr && t_a == 8'h18) ? t_d : '0;
      t_st   = m_pend & m_en & ~m_fen;
      m_irq  = (t_st != 0);
      m_firq = ((m_pend & m_fen) != 0);
      m_vvalid = (t_st != 0);
      m_vid    = '0;
      t_found  = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
        if (t_st[i] && !t_found) begin
          m_vid   = 5'(i);
          t_found = 1'b1;
        end
      end
      for (int i = 0; i < N_SRC; i++) begin
        if (m_mode[i]) begin
          t_lat[i]  = (m_lat[i] && !t_w1c[i]) || t_rise[i];
          m_pend[i] = t_lat[i] || m_soft[i];
        end else begin
          t_lat[i]  = 1'b0;
          m_pend[i] = t_s[i] || m_soft[i];
        end
      end
      m_lat = t_lat;
      if (t_wr) begin
        case (t_a)
          8'h08: m_en   = m_en | t_d;
          8'h0C: m_en   = m_en & ~t_d;
          8'h10: m_soft = m_soft | t_d;
          8'h14: m_soft = m_soft & ~t_d;
          8'h1C: m_mode = t_d;
          8'h28: m_fen  = m_fen | t_d;
          8'h2C: m_fen  = m_fen & ~t_d;
          default: ;
        endcase
      end
      for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = int_in;
    end
  end

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] r;
    r = 32'h2233_4455;
    case (a)
      8'h00: r = 32'(m_pend & m_en & ~m_fen);
      8'h04: r = 32'(m_hist[SS-1]);
      8'h08: r = 32'(m_en);
      8'h10: r = 32'(m_soft);
      8'h18: r = 32'(m_pend);
      8'h1C: r = 32'(m_mode);
      8'h20: r = 32'(m_pend & m_fen);
      8'h28: r = 32'(m_fen);
      8'h30: r = {m_vvalid, 26'd0, m_vid};
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live && rst_n) begin
      chk("o_irq", 32'(irq), 32'(m_irq));
      chk("o_firq", 32'(firq), 32'(m_firq));
      chk("o_wb_err", 32'(err), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    adr = {24'h0, a}; dat_w = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    @(negedge clk);
    chk("write ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; cyc = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
    logic [31:0] exp;
    @(posedge clk); #1;
    adr = {24'h0, a}; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    exp = model_read(a);
    @(negedge clk);
    chk("read ack early", 32'(ack), 32'd0);
    @(negedge clk);
    chk("read ack", 32'(ack), 32'd1);
    chk($sformatf("read %02h", a), dat_r, exp);
    d = dat_r;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  int n;
  logic [7:0] wr_addrs [14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h40};
  logic [7:0] rd_addrs [11] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h18, 8'h1C,
                                8'h20, 8'h24, 8'h28, 8'h30, 8'h40};

  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // reset state
    wb_read(8'h08, rd); chk("reset irq_en", rd, 32'h0);
    wb_read(8'h1C, rd); chk("reset mode", rd, 32'h0);
    wb_read(8'h30, rd); chk("reset vector", rd, 32'h0);
    wb_read(8'h40, rd); chk("unmapped read", rd, 32'h2233_4455);
    chk("reset o_irq", 32'(irq), 32'd0);
    chk("reset o_firq", 32'(firq), 32'd0);

    // level mode latency
    wb_write(8'h08, 32'h0010);
    idle(2);
    int_in[4] = 1'b1;
    n = 0;
    while (!irq && n < 20) begin @(posedge clk); #1; n++; end
    chk("level rise latency", 32'(n), 32'd4);
    wb_read(8'h00, rd); chk("level irq_status", rd, 32'h0010);
    idle(3);
    int_in[4] = 1'b0;
    n = 0;
    while (irq && n < 20) begin @(posedge clk); #1; n++; end
    chk("level fall latency", 32'(n), 32'd4);

    // edge mode latch and W1C
    wb_write(8'h1C, 32'h0008);
    wb_write(8'h08, 32'h0008);
    int_in[3] = 1'b1;
    @(posedge clk); #1;
    int_in[3] = 1'b0;
    idle(5);
    wb_read(8'h18, rd); chk("edge pending", rd, 32'h0008);
    chk("edge o_irq held", 32'(irq), 32'd1);
    wb_write(8'h18, 32'h0008);
    @(negedge clk); chk("w1c irq +1", 32'(irq), 32'd1);
    @(negedge clk); chk("w1c irq +2", 32'(irq), 32'd0);
    wb_read(8'h18, rd); chk("edge pending cleared", rd, 32'h0);

    // W1C landing on the same edge that captures a new rise
    idle(3);
    int_in[3] = 1'b1;
    @(posedge clk); #1;
    int_in[3] = 1'b0;
    wb_write(8'h18, 32'h0008);
    wb_read(8'h18, rd); chk("simultaneous set wins", rd & 32'h8, 32'h8);
    wb_write(8'h18, 32'h0008);

    // priority and FIRQ steering
    wb_write(8'h1C, 32'h0);
    wb_write(8'h0C, 32'hFFFF);
    wb_write(8'h08, 32'h0224);
    wb_write(8'h28, 32'h0020);
    int_in = 16'h0224;
    idle(6);
    wb_read(8'h30, rd); chk("vector lowest", rd, 32'h8000_0002);
    wb_read(8'h20, rd); chk("firq_status", rd, 32'h0020);
    wb_read(8'h00, rd); chk("irq_status", rd, 32'h0204);
    wb_write(8'h0C, 32'h0004);
    idle(3);
    wb_read(8'h30, rd); chk("vector after enclr", rd, 32'h8000_0009);
    int_in = '0;
    wb_write(8'h2C, 32'hFFFF);
    wb_write(8'h0C, 32'hFFFF);
    idle(6);

    // soft interrupt, then reset in the middle of a read
    wb_write(8'h10, 32'h0001);
    wb_write(8'h08, 32'h0001);
    idle(4);
    chk("soft o_irq", 32'(irq), 32'd1);
    @(posedge clk); #1;
    adr = 32'h18; we = 1'b0; stb = 1'b1; cyc = 1'b1; rst_n = 1'b0;
    @(negedge clk); chk("reset read ack c1", 32'(ack), 32'd0);
    @(negedge clk); chk("reset read ack c2", 32'(ack), 32'd0);
    chk("reset o_irq mid", 32'(irq), 32'd0);
    chk("reset o_firq mid", 32'(firq), 32'd0);
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; rst_n = 1'b1;
    wb_read(8'h08, rd); chk("post-reset irq_en", rd, 32'h0);
    wb_read(8'h10, rd); chk("post-reset soft", rd, 32'h0);
    wb_read(8'h18, rd); chk("post-reset pending", rd, 32'h0);

    // random traffic against the model
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0: wb_write(wr_addrs[$urandom_range(0, 13)], $urandom);
        1: wb_read(rd_addrs[$urandom_range(0, 10)], rd);
        2: begin @(posedge clk); #1; int_in = N_SRC'($urandom); end
        default: idle($urandom_range(1, 4));
      endcase
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
